// File: rtl/dtm_dmi_engine.sv
// dtm_dmi_engine: JTAG DTM DTMCS/DMI register engine with request/response FSM, TCK domain
module dtm_dmi_engine #(
  parameter int ABITS       = 7,
  parameter int IDLE_CYCLES = 1,
  parameter int DTM_VERSION = 1
) (
  input  logic             tck_i,
  input  logic             rst_i,
  input  logic             capture_i,
  input  logic             shift_i,
  input  logic             update_i,
  input  logic             tdi_i,
  input  logic             dmi_select_i,
  input  logic             dtmcs_select_i,
  output logic             dmi_tdo_o,
  output logic             dtmcs_tdo_o,
  output logic             dmi_clear_o,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_resp_i,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o
);
  localparam int DW = ABITS + 34;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t           r_state;
  logic [1:0]       r_error;
  logic [ABITS-1:0] r_last_addr;
  logic [ABITS-1:0] r_req_addr;
  logic [31:0]      r_last_data;
  logic [31:0]      r_req_data;
  logic [1:0]       r_req_op;
  logic             r_req_valid;
  logic             r_resp_ready;
  logic             r_clear;
  logic [31:0]      r_dtmcs_sr;
  logic [DW-1:0]    r_dmi_sr;
  logic             w_dtmcs_cap, w_dtmcs_shift, w_dtmcs_upd;
  logic             w_dmi_cap, w_dmi_shift, w_dmi_upd;
  logic             w_hardreset, w_busy, w_op_valid;
  logic [1:0]       w_dmi_status;
  logic [31:0]      w_dtmcs_val;
  logic             w_unused;
  assign w_dtmcs_cap   = dtmcs_select_i & capture_i;
  assign w_dtmcs_shift = dtmcs_select_i & shift_i;
  assign w_dtmcs_upd   = dtmcs_select_i & update_i;
  assign w_dmi_cap     = dmi_select_i & capture_i;
  assign w_dmi_shift   = dmi_select_i & shift_i;
  assign w_dmi_upd     = dmi_select_i & update_i;
  assign w_hardreset   = w_dtmcs_upd & r_dtmcs_sr[17];
  assign w_busy        = r_state != S_IDLE;
  assign w_op_valid    = r_dmi_sr[1:0] == 2'd1 || r_dmi_sr[1:0] == 2'd2;
  // a busy capture reports 3 even though the sticky error only latches it on this same edge
  assign w_dmi_status  = r_error != 2'd0 ? r_error : w_busy ? 2'd3 : 2'd0;
  assign w_dtmcs_val   = {17'd0, 3'(IDLE_CYCLES), r_error, 6'(ABITS), 4'(DTM_VERSION)};
  assign w_unused      = ^{r_dtmcs_sr[31:18], r_dtmcs_sr[15:0]};
  assign dmi_tdo_o        = r_dmi_sr[0];
  assign dtmcs_tdo_o      = r_dtmcs_sr[0];
  assign dmi_clear_o      = r_clear;
  assign dmi_req_addr_o   = r_req_addr;
  assign dmi_req_data_o   = r_req_data;
  assign dmi_req_op_o     = r_req_op;
  assign dmi_req_valid_o  = r_req_valid;
  assign dmi_resp_ready_o = r_resp_ready;
  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_error      <= 2'd0;
      r_last_addr  <= '0;
      r_req_addr   <= '0;
      r_last_data  <= '0;
      r_req_data   <= '0;
      r_req_op     <= '0;
      r_req_valid  <= 1'b0;
      r_resp_ready <= 1'b0;
      r_clear      <= 1'b0;
      r_dtmcs_sr   <= '0;
      r_dmi_sr     <= '0;
    end else begin
      r_clear <= w_hardreset;
      if (w_dtmcs_cap) r_dtmcs_sr <= w_dtmcs_val;
      else if (w_dtmcs_shift) r_dtmcs_sr <= {tdi_i, r_dtmcs_sr[31:1]};
      if (w_dmi_cap) r_dmi_sr <= {r_last_addr, r_last_data, w_dmi_status};
      else if (w_dmi_shift) r_dmi_sr <= {tdi_i, r_dmi_sr[DW-1:1]};
      if (r_state == S_REQ && dmi_req_ready_i) begin
        r_state      <= S_WAIT;
        r_req_valid  <= 1'b0;
        r_resp_ready <= 1'b1;
      end
      if (r_state == S_WAIT && dmi_resp_valid_i && !w_hardreset) begin
        r_last_data  <= dmi_resp_data_i;
        r_state      <= S_IDLE;
        r_resp_ready <= 1'b0;
        if (dmi_resp_resp_i[1] && r_error == 2'd0) r_error <= dmi_resp_resp_i;
      end
      if (w_dmi_cap && w_busy && r_error == 2'd0) r_error <= 2'd3;
      if (w_dmi_upd && r_error == 2'd0) begin
        if (w_busy) r_error <= 2'd3;
        else if (w_op_valid) begin
          r_req_addr  <= r_dmi_sr[DW-1:34];
          r_last_addr <= r_dmi_sr[DW-1:34];
          r_req_data  <= r_dmi_sr[33:2];
          r_req_op    <= r_dmi_sr[1:0];
          r_req_valid <= 1'b1;
          r_state     <= S_REQ;
        end
      end
      // hardreset is a superset of dmireset and abandons any transaction in flight
      if (w_dtmcs_upd && (r_dtmcs_sr[16] || r_dtmcs_sr[17])) r_error <= 2'd0;
      if (w_hardreset) begin
        r_state      <= S_IDLE;
        r_req_valid  <= 1'b0;
        r_resp_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dtm_dmi_engine.sv
// tb_dtm_dmi_engine: directed self-checking bench for dtm_dmi_engine
module tb_dtm_dmi_engine;
  localparam int DW = 41;
  logic        tck_i = 0, rst_i = 0, capture_i = 0, shift_i = 0, update_i = 0, tdi_i = 0;
  logic        dmi_select_i = 0, dtmcs_select_i = 0;
  logic        dmi_tdo_o, dtmcs_tdo_o, dmi_clear_o, dmi_req_valid_o, dmi_resp_ready_o;
  logic [6:0]  dmi_req_addr_o;
  logic [31:0] dmi_req_data_o;
  logic [1:0]  dmi_req_op_o;
  logic        dmi_req_ready_i = 0, dmi_resp_valid_i = 0;
  logic [31:0] dmi_resp_data_i = 0;
  logic [1:0]  dmi_resp_resp_i = 0;
  int checks = 0, errors = 0;
  logic [31:0] dtmcs_out;
  logic [DW-1:0] dmi_out;

  dtm_dmi_engine dut (
    .tck_i(tck_i), .rst_i(rst_i), .capture_i(capture_i), .shift_i(shift_i),
    .update_i(update_i), .tdi_i(tdi_i), .dmi_select_i(dmi_select_i),
    .dtmcs_select_i(dtmcs_select_i), .dmi_tdo_o(dmi_tdo_o), .dtmcs_tdo_o(dtmcs_tdo_o),
    .dmi_clear_o(dmi_clear_o), .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o),
    .dmi_req_op_o(dmi_req_op_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_data_i(dmi_resp_data_i), .dmi_resp_resp_i(dmi_resp_resp_i),
    .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o)
  );

  always #5 tck_i = ~tck_i;

  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dtmcs_scan(input logic [31:0] din, input bit upd, output logic [31:0] dout);
    dtmcs_select_i = 1;
    capture_i = 1;
    tick();
    capture_i = 0;
    shift_i = 1;
    for (int i = 0; i < 32; i++) begin
      dout[i] = dtmcs_tdo_o;
      tdi_i = din[i];
      tick();
    end
    shift_i = 0;
    if (upd) begin
      update_i = 1;
      tick();
      update_i = 0;
    end
    dtmcs_select_i = 0;
  endtask

  task automatic dmi_scan(input logic [DW-1:0] din, input bit upd, output logic [DW-1:0] dout);
    dmi_select_i = 1;
    capture_i = 1;
    tick();
    capture_i = 0;
    shift_i = 1;
    for (int i = 0; i < DW; i++) begin
      dout[i] = dmi_tdo_o;
      tdi_i = din[i];
      tick();
    end
    shift_i = 0;
    if (upd) begin
      update_i = 1;
      tick();
      update_i = 0;
    end
    dmi_select_i = 0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] resp);
    dmi_req_ready_i = 1;
    tick();
    dmi_req_ready_i = 0;
    chk("wait_resp_ready", dmi_resp_ready_o, 1);
    dmi_resp_valid_i = 1;
    dmi_resp_data_i = data;
    dmi_resp_resp_i = resp;
    tick();
    dmi_resp_valid_i = 0;
    chk("idle_resp_ready", dmi_resp_ready_o, 0);
  endtask

  initial begin
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    chk("rst_valid", dmi_req_valid_o, 0);
    chk("rst_resp_ready", dmi_resp_ready_o, 0);
    chk("rst_clear", dmi_clear_o, 0);
    chk("rst_addr", dmi_req_addr_o, 0);
    chk("rst_data", dmi_req_data_o, 0);
    chk("rst_op", dmi_req_op_o, 0);
    dtmcs_scan(32'h0, 0, dtmcs_out);
    chk("dtmcs_reset_val", dtmcs_out, 32'h0000_1071);

    dmi_scan({7'h10, 32'h8000_0001, 2'd2}, 1, dmi_out);
    chk("wr_capture_idle", dmi_out, 0);
    for (int c = 0; c < 3; c++) begin
      chk("wr_valid", dmi_req_valid_o, 1);
      chk("wr_addr", dmi_req_addr_o, 7'h10);
      chk("wr_data", dmi_req_data_o, 32'h8000_0001);
      chk("wr_op", dmi_req_op_o, 2);
      if (c < 2) tick();
    end
    dmi_req_ready_i = 1;
    tick();
    dmi_req_ready_i = 0;
    chk("wr_valid_drop", dmi_req_valid_o, 0);
    chk("wr_resp_ready", dmi_resp_ready_o, 1);
    dmi_resp_valid_i = 1;
    dmi_resp_data_i = 32'h1111_1111;
    dmi_resp_resp_i = 0;
    tick();
    dmi_resp_valid_i = 0;
    chk("wr_resp_ready_drop", dmi_resp_ready_o, 0);
    dmi_scan('0, 0, dmi_out);
    chk("wr_capture", dmi_out, {7'h10, 32'h1111_1111, 2'd0});

    dmi_scan({7'h04, 32'h0, 2'd1}, 1, dmi_out);
    chk("rd_valid", dmi_req_valid_o, 1);
    chk("rd_addr", dmi_req_addr_o, 7'h04);
    chk("rd_op", dmi_req_op_o, 1);
    respond(32'hCAFE_F00D, 0);
    dmi_scan('0, 0, dmi_out);
    chk("rd_capture", dmi_out, {7'h04, 32'hCAFE_F00D, 2'd0});

    dmi_scan({7'h05, 32'h5555_5555, 2'd2}, 1, dmi_out);
    dmi_req_ready_i = 1;
    tick();
    dmi_req_ready_i = 0;
    dmi_scan({7'h06, 32'h6666_6666, 2'd1}, 1, dmi_out);
    chk("busy_capture_status", dmi_out[1:0], 3);
    chk("busy_ignored_valid", dmi_req_valid_o, 0);
    chk("busy_ignored_addr", dmi_req_addr_o, 7'h05);
    chk("busy_still_wait", dmi_resp_ready_o, 1);
    dtmcs_scan(32'h0, 0, dtmcs_out);
    chk("dtmcs_busy", dtmcs_out, 32'h0000_1C71);
    dmi_resp_valid_i = 1;
    dmi_resp_data_i = 32'h0;
    tick();
    dmi_resp_valid_i = 0;
    dtmcs_scan(32'h0001_0000, 1, dtmcs_out);
    dtmcs_scan(32'h0, 0, dtmcs_out);
    chk("dmireset_clears", dtmcs_out, 32'h0000_1071);

    dmi_scan({7'h08, 32'h0, 2'd1}, 1, dmi_out);
    respond(32'hDEAD_0002, 2);
    dmi_scan('0, 0, dmi_out);
    chk("failed_capture", dmi_out, {7'h08, 32'hDEAD_0002, 2'd2});
    dmi_scan({7'h09, 32'h0, 2'd1}, 1, dmi_out);
    chk("failed_blocks_req", dmi_req_valid_o, 0);
    dtmcs_scan(32'h0, 0, dtmcs_out);
    chk("sticky_failed", dtmcs_out, 32'h0000_1871);
    dtmcs_scan(32'h0001_0000, 1, dtmcs_out);

    dmi_scan({7'h0A, 32'hA5A5_A5A5, 2'd2}, 1, dmi_out);
    chk("hr_req_valid", dmi_req_valid_o, 1);
    dtmcs_scan(32'h0003_0000, 1, dtmcs_out);
    chk("hr_clear_pulse", dmi_clear_o, 1);
    chk("hr_valid_drop", dmi_req_valid_o, 0);
    tick();
    chk("hr_clear_end", dmi_clear_o, 0);
    dmi_scan({7'h0B, 32'h0, 2'd1}, 1, dmi_out);
    chk("hr_capture_idle", dmi_out[1:0], 0);
    chk("hr_new_valid", dmi_req_valid_o, 1);
    chk("hr_new_addr", dmi_req_addr_o, 7'h0B);

    rst_i = 1;
    tick();
    rst_i = 0;
    chk("midrst_valid", dmi_req_valid_o, 0);
    chk("midrst_clear", dmi_clear_o, 0);
    chk("midrst_addr", dmi_req_addr_o, 0);
    dmi_resp_valid_i = 1;
    dmi_resp_data_i = 32'hBAD0_BAD0;
    tick();
    chk("idle_no_consume_ready", dmi_resp_ready_o, 0);
    dmi_resp_valid_i = 0;
    dmi_scan('0, 0, dmi_out);
    chk("idle_no_consume_data", dmi_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dtm_dmi_engine.md
Name: dtm_dmi_engine

Overview:
- Parametrised DMI/DTMCS register engine for the JTAG DTM, running in the TCK domain.
- Sits between the TAP controller (capture/shift/update/select strobes) and the CDC toward the Debug Module.
- Successor to the fixed-width DTM register block. Adds:
  - configurable address width, idle hint and version;
  - sticky busy/failed error tracking;
  - dmireset and dmihardreset handling;
  - a request/response FSM with flat parametrised ports.

Parameters:
ABITS, 7, DMI address width (1..32); DMI scan width DW = ABITS+34
IDLE_CYCLES, 1, value reported in dtmcs.idle (3 bits)
DTM_VERSION, 1, value reported in dtmcs.version (4 bits)

Ports:
tck_i  in  1  JTAG test clock, sole clock
rst_i  in  1  synchronous active-high reset
capture_i  in  1  TAP Capture-DR strobe
shift_i  in  1  TAP Shift-DR strobe
update_i  in  1  TAP Update-DR strobe
tdi_i  in  1  serial data in
dmi_select_i  in  1  DMI register selected by IR
dtmcs_select_i  in  1  DTMCS register selected by IR
dmi_tdo_o  out  1  DMI shift register LSB
dtmcs_tdo_o  out  1  DTMCS shift register LSB
dmi_clear_o  out  1  one-cycle pulse on dmihardreset
dmi_req_addr_o  out  ABITS  request address
dmi_req_data_o  out  32  request write data
dmi_req_op_o  out  2  request op (1 = read, 2 = write)
dmi_req_valid_o  out  1  request valid
dmi_req_ready_i  in  1  request accepted
dmi_resp_data_i  in  32  response data
dmi_resp_resp_i  in  2  response status (0 = ok, 2 = failed, 3 = busy)
dmi_resp_valid_i  in  1  response valid
dmi_resp_ready_o  out  1  response ready

Behaviour:

Reset and general rules:
- Synchronous, active-high reset clears all state.
- Reset values: all outputs 0; FSM Idle; error = 0; shift registers 0; last address and last data = 0.
- Strobes act only when the matching select is high.
- Capture, shift and update are mutually exclusive per cycle.

DTMCS register (32 bits):
- Capture value: [31:18]=0, [17]=0, [16]=0, [15]=0, [14:12]=IDLE_CYCLES, [11:10]=error, [9:4]=ABITS, [3:0]=DTM_VERSION.
- Shift: register shifts right, tdi_i enters bit 31. dtmcs_tdo_o = bit 0.
- Update, bit 16 (dmireset): error <= 0.
- Update, bit 17 (dmihardreset):
  - error <= 0, FSM <= Idle, dmi_clear_o = 1 for exactly the next cycle;
  - any outstanding request or response is abandoned.
- If bits 16 and 17 are both set, perform the hardreset action (it is a superset of dmireset).

DMI register (DW bits):
- Layout: [DW-1:34] address, [33:2] data, [1:0] op.
- Capture value: {last_addr, last_data, status}.
  - status = error if error != 0.
  - Otherwise status = 3 if FSM != Idle; on that same edge, error <= 3.
  - Otherwise status = 0.
- Shift: register shifts right, tdi_i enters the MSB. dmi_tdo_o = bit 0.
- Update:
  - If error != 0: the request is ignored.
  - Else if FSM != Idle: error <= 3 and the request is ignored.
  - Else if op is 1 or 2: latch address, data and op into the request registers and last_addr; FSM -> Req.
  - Op 0 and op 3 are no-ops.

FSM:
- Idle: valid = 0, resp_ready = 0.
- Req: dmi_req_valid_o = 1. Address, data and op are held stable until dmi_req_ready_i. On ready, go to Wait on the next cycle.
- Wait: dmi_resp_ready_o = 1. On dmi_resp_valid_i:
  - last_data <= dmi_resp_data_i;
  - if resp = 2 or 3 and error = 0, then error <= resp;
  - FSM -> Idle.
- Minimum latency, update to valid: 1 cycle.
- Minimum latency, ready to resp_ready: 1 cycle.

Sticky error:
- First nonzero error wins; later errors do not overwrite it.
- Cleared only by dmireset, dmihardreset or rst_i.

Boundary cases:
- Response while not in Wait: not consumed (ready = 0).
- Hardreset while in Req: valid deasserts next cycle. The DM side is flushed via dmi_clear_o.
- Hardreset while in Wait: no response is consumed.
- Reset mid-transaction: everything returns to reset values next cycle; no pulse on dmi_clear_o.

Test Plan:
1. rst_i, then DTMCS capture and 32 shifts -> dtmcs_tdo_o serialises 0x00001071 LSB first (ABITS = 7, IDLE = 1, version = 1).
2. DMI update op=2, addr=0x10, data=0x80000001; ready after 3 cycles; response ok -> request fields stable for 3 cycles with valid = 1. Next capture shifts out status 0 and addr 0x10.
3. DMI read addr=0x04; response data 0xCAFEF00D, resp=0 -> next capture returns data 0xCAFEF00D, status 0.
4. Second update while in Wait -> ignored and error = 3. A DTMCS capture then shows dmistat = 3. DTMCS update with bit 16 -> error = 0.
5. Response resp = 2 -> DMI capture status 2. A later busy condition leaves error at 2 (first error wins).
6. dmihardreset while in Req -> dmi_clear_o high for exactly 1 cycle; valid = 0 next cycle; FSM Idle; a new read is accepted immediately.
